// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared owner encoding and default bus widths for the
// SRAM port arbiter slice.
package cpu_defs_pkg;

    localparam int SRAM_ADDR_W = 32;
    localparam int SRAM_DATA_W = 32;

    // Which requester owns the access that was issued in the previous cycle
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: fetch port, memory-stage port and SRAM port of the
// shared-SRAM arbiter. The arbiter connects through the slave modport, the
// pipeline/memory side through the master modport.
interface sram_port_arbiter_if
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
);
    localparam int BE_W = DATA_W / 8;

    // fetch port
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_cancel;
    logic              inst_gnt;
    logic              inst_rvalid;
    logic [DATA_W-1:0] inst_rdata;

    // memory-stage port
    logic              data_req;
    logic [BE_W-1:0]   data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;

    // SRAM port
    logic              sram_en;
    logic [BE_W-1:0]   sram_wen;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr, inst_cancel,
        output inst_gnt, inst_rvalid, inst_rdata,
        input  data_req, data_wen, data_addr, data_wdata,
        output data_gnt, data_rvalid, data_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output inst_req, inst_addr, inst_cancel,
        input  inst_gnt, inst_rvalid, inst_rdata,
        output data_req, data_wen, data_addr, data_wdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata,
        output sram_rdata
    );

endinterface

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: counts consecutive data grants taken while a fetch is
// waiting and raises force_inst once STARVE_MAX of them have happened.
// Only instantiated when ARB_STARVE_GUARD_EN is defined.
module arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic inst_req,
    input  logic inst_gnt,
    input  logic data_gnt,
    output logic force_inst
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt_p1;

    // Saturating count of data wins over a waiting fetch; any fetch grant or
    // a withdrawn fetch request restarts the count
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_p1 <= '0;
        end else if (!inst_req || inst_gnt) begin
            cnt_p1 <= '0;
        end else if (data_gnt && (cnt_p1 != CNT_MAX)) begin
            cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    assign force_inst = (cnt_p1 == CNT_MAX);

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port synchronous SRAM between the
// fetch port (read-only) and the memory-stage port (read/write). At most one
// access is issued per cycle, data has priority, and the read data returned
// one cycle later is steered to whichever port owned the access.
// Optional feature macro: ARB_STARVE_GUARD_EN (bounded fetch starvation).
module sram_port_arbiter
    import cpu_defs_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
    parameter int unsigned STARVE_MAX = 4
)
`endif
(
    input  logic               clk,
    input  logic               resetn,
    sram_port_arbiter_if.slave bus
);
    owner_t owner_p1;
    owner_t owner_nxt;
    logic   killed_p1;
    logic   killed_nxt;
    logic   load_p1;
    logic   load_nxt;
    logic   force_inst;
    logic   data_sel;
    logic   inst_sel;
    logic   inst_ok;

`ifdef ARB_STARVE_GUARD_EN
    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk        (clk),
        .resetn     (resetn),
        .inst_req   (bus.inst_req),
        .inst_gnt   (inst_sel),
        .data_gnt   (data_sel),
        .force_inst (force_inst)
    );
`else
    assign force_inst = 1'b0;
`endif

    // Grant selection: data first unless a starved fetch is being forced;
    // nothing is granted while reset is held
    always_comb begin
        data_sel = 1'b0;
        inst_sel = 1'b0;
        if (resetn) begin
            if (bus.data_req && !(force_inst && bus.inst_req)) begin
                data_sel = 1'b1;
            end else if (bus.inst_req) begin
                inst_sel = 1'b1;
            end
        end
    end

    assign bus.data_gnt   = data_sel;
    assign bus.inst_gnt   = inst_sel;
    assign bus.sram_en    = data_sel | inst_sel;
    assign bus.sram_wen   = data_sel ? bus.data_wen   : '0;
    assign bus.sram_addr  = data_sel ? bus.data_addr  : bus.inst_addr;
    assign bus.sram_wdata = data_sel ? bus.data_wdata : '0;

    // Owner state register, plus the kill and load-vs-store flags of the
    // access in flight; reset discards whatever was in flight
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_p1  <= OWN_IDLE;
            killed_p1 <= 1'b0;
            load_p1   <= 1'b0;
        end else begin
            owner_p1  <= owner_nxt;
            killed_p1 <= killed_nxt;
            load_p1   <= load_nxt;
        end
    end

    // Next owner and response steering. A cancel in a cycle where an older
    // fetch is already in its response cycle targets that older fetch, so a
    // redirect fetch granted alongside the cancel is kept alive.
    always_comb begin
        owner_nxt  = OWN_IDLE;
        killed_nxt = 1'b0;
        load_nxt   = 1'b0;
        if (data_sel) begin
            owner_nxt = OWN_D;
            load_nxt  = (bus.data_wen == '0);
        end else if (inst_sel) begin
            owner_nxt  = OWN_I;
            killed_nxt = bus.inst_cancel && (owner_p1 != OWN_I);
        end
        inst_ok         = (owner_p1 == OWN_I) && !killed_p1 && !bus.inst_cancel;
        bus.inst_rvalid = inst_ok;
        bus.inst_rdata  = inst_ok ? bus.sram_rdata : '0;
        bus.data_rvalid = (owner_p1 == OWN_D);
        bus.data_rdata  = ((owner_p1 == OWN_D) && load_p1) ? bus.sram_rdata : '0;
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed scenarios followed by randomized traffic.
// A reference model predicts grants, SRAM drive and the response of every
// access from the arbitration rules and a private memory image; expected
// responses are queued and a separate monitor pops and compares them.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
    import cpu_defs_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_port_arbiter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int idx);
        if (idx == 0) return 32'h3C010001;
        return (idx * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // ---------------- SRAM behavioural model (driven by DUT sram_* only)
    logic [31:0] sram_mem [0:1023];
    bit          sram_wr  [0:1023];

    function automatic logic [31:0] sram_word(input int idx);
        return sram_wr[idx] ? sram_mem[idx] : init_word(idx);
    endfunction

    always @(posedge clk) begin
        if (bus.sram_en) begin
            bus.sram_rdata <= sram_word(int'(bus.sram_addr[11:2]));
            if (bus.sram_wen != 4'd0) begin
                sram_mem[bus.sram_addr[11:2]] <= merge(sram_word(int'(bus.sram_addr[11:2])),
                                                       bus.sram_wen, bus.sram_wdata);
                sram_wr[bus.sram_addr[11:2]]  <= 1'b1;
            end
        end
    end

    // ---------------- reference model
    typedef struct {
        bit          kill;
        logic [31:0] data;
        int          gcyc;
    } resp_t;

    resp_t iq[$];
    resp_t dq[$];

    logic [31:0] ref_mem [0:1023];
    bit          ref_wr  [0:1023];
    int          starve  = 0;
    bit          prev_i  = 1'b0;
    bit          exp_ig  = 1'b0;
    bit          exp_dg  = 1'b0;

    function automatic logic [31:0] ref_word(input int idx);
        return ref_wr[idx] ? ref_mem[idx] : init_word(idx);
    endfunction

    always @(negedge clk) begin
        bit    frc, dwin, iwin;
        resp_t e;
        int    idx;
        if (!resetn) begin
            chk("rst_inst_gnt", bus.inst_gnt, 0);
            chk("rst_data_gnt", bus.data_gnt, 0);
            chk("rst_sram_en", bus.sram_en, 0);
            chk("rst_sram_wen", bus.sram_wen, 0);
            starve = 0;
            prev_i = 1'b0;
            exp_ig = 1'b0;
            exp_dg = 1'b0;
        end else begin
`ifdef ARB_STARVE_GUARD_EN
            frc = (starve >= SMAX);
`else
            frc = 1'b0;
`endif
            dwin = bus.data_req && !(frc && bus.inst_req);
            iwin = !dwin && bus.inst_req;
            chk("inst_gnt", bus.inst_gnt, iwin);
            chk("data_gnt", bus.data_gnt, dwin);
            chk("sram_en", bus.sram_en, dwin | iwin);
            if (dwin) begin
                chk("sram_wen_d", bus.sram_wen, bus.data_wen);
                chk("sram_addr_d", bus.sram_addr, bus.data_addr);
                chk("sram_wdata_d", bus.sram_wdata, bus.data_wdata);
                idx    = int'(bus.data_addr[11:2]);
                e.kill = 1'b0;
                e.gcyc = cyc;
                e.data = (bus.data_wen == 4'd0) ? ref_word(idx) : 32'd0;
                dq.push_back(e);
                if (bus.data_wen != 4'd0) begin
                    ref_mem[idx] = merge(ref_word(idx), bus.data_wen, bus.data_wdata);
                    ref_wr[idx]  = 1'b1;
                end
            end else if (iwin) begin
                chk("sram_wen_i", bus.sram_wen, 0);
                chk("sram_addr_i", bus.sram_addr, bus.inst_addr);
                e.kill = bus.inst_cancel && !prev_i;
                e.gcyc = cyc;
                e.data = ref_word(int'(bus.inst_addr[11:2]));
                iq.push_back(e);
            end else begin
                chk("sram_wen_idle", bus.sram_wen, 0);
            end
            if (!bus.inst_req || iwin) starve = 0;
            else if (dwin && starve < SMAX) starve++;
            prev_i = iwin;
            exp_ig = iwin;
            exp_dg = dwin;
        end
    end

    // ---------------- response monitor
    always @(negedge clk) begin
        resp_t e;
        bit    v;
        if (!resetn) begin
            chk("rst_inst_rvalid", bus.inst_rvalid, 0);
            chk("rst_data_rvalid", bus.data_rvalid, 0);
            chk("rst_inst_rdata", bus.inst_rdata, 0);
            chk("rst_data_rdata", bus.data_rdata, 0);
            iq.delete();
            dq.delete();
        end else begin
            if (iq.size() > 0 && iq[0].gcyc == cyc - 1) begin
                e = iq.pop_front();
                v = !(e.kill || bus.inst_cancel);
                chk("inst_rvalid", bus.inst_rvalid, v);
                chk("inst_rdata", bus.inst_rdata, v ? e.data : 32'd0);
            end else begin
                chk("inst_rvalid_idle", bus.inst_rvalid, 0);
                chk("inst_rdata_idle", bus.inst_rdata, 0);
            end
            if (dq.size() > 0 && dq[0].gcyc == cyc - 1) begin
                e = dq.pop_front();
                chk("data_rvalid", bus.data_rvalid, 1);
                chk("data_rdata", bus.data_rdata, e.data);
            end else begin
                chk("data_rvalid_idle", bus.data_rvalid, 0);
                chk("data_rdata_idle", bus.data_rdata, 0);
            end
        end
    end

    // ---------------- stimulus
    task automatic setv(input bit ir, input logic [31:0] ia, input bit ic, input bit dr,
                        input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        bus.inst_req    = ir;
        bus.inst_addr   = ia;
        bus.inst_cancel = ic;
        bus.data_req    = dr;
        bus.data_wen    = dw;
        bus.data_addr   = da;
        bus.data_wdata  = dd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) setv(0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        bus.inst_req    = 1'b1;
        bus.inst_addr   = 32'h0000_0010;
        bus.inst_cancel = 1'b0;
        bus.data_req    = 1'b1;
        bus.data_wen    = 4'b1111;
        bus.data_addr   = 32'h0000_0020;
        bus.data_wdata  = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
        idle(1);

        // fetch from reset vector
        setv(1, 32'hBFC0_0000, 0, 0, 4'd0, 32'd0, 32'd0);
        idle(2);
        // simultaneous fetch and load: load first, fetch next cycle
        setv(1, 32'h0000_0040, 0, 1, 4'd0, 32'h0000_0100, 32'd0);
        setv(1, 32'h0000_0040, 0, 0, 4'd0, 32'd0, 32'd0);
        idle(2);
        // partial store, then load it back
        setv(0, 32'd0, 0, 1, 4'b0011, 32'h0000_0200, 32'hAABB_CCDD);
        setv(0, 32'd0, 0, 1, 4'd0, 32'h0000_0200, 32'd0);
        idle(2);
        // cancel of an in-flight fetch with redirect fetch granted alongside
        setv(1, 32'h0000_0044, 0, 0, 4'd0, 32'd0, 32'd0);
        setv(1, 32'h0000_0048, 1, 0, 4'd0, 32'd0, 32'd0);
        idle(2);
        // cancel in the grant cycle of a lone fetch
        setv(1, 32'h0000_004C, 1, 0, 4'd0, 32'd0, 32'd0);
        idle(2);
        // reset during the response cycle of a load
        setv(0, 32'd0, 0, 1, 4'd0, 32'h0000_0104, 32'd0);
        setv(1, 32'h0000_0050, 0, 1, 4'd0, 32'h0000_0108, 32'd0);
        resetn = 1'b0;
        setv(1, 32'h0000_0050, 0, 1, 4'd0, 32'h0000_0108, 32'd0);
        setv(0, 32'd0, 0, 0, 4'd0, 32'd0, 32'd0);
        resetn = 1'b1;
        idle(2);
        // sustained contention
        for (int i = 0; i < 6; i++)
            setv(1, 32'h0000_0054, 0, 1, 4'd0, 32'h0000_0110, 32'd0);
        idle(2);

        // randomized traffic, requests held until granted
        for (int n = 0; n < 800; n++) begin
            @(posedge clk);
            #1;
            if (n == 400) resetn = 1'b0;
            if (n == 402) resetn = 1'b1;
            if (!(bus.inst_req && !exp_ig)) begin
                bus.inst_req  = ($urandom_range(0, 3) != 0);
                bus.inst_addr = $urandom() & 32'hFFFF_F03C;
            end
            if (!(bus.data_req && !exp_dg)) begin
                bus.data_req   = ($urandom_range(0, 2) != 0);
                bus.data_wen   = ($urandom_range(0, 1) != 0) ? 4'($urandom()) : 4'd0;
                bus.data_addr  = $urandom() & 32'hFFFF_F03C;
                bus.data_wdata = $urandom();
            end
            bus.inst_cancel = ($urandom_range(0, 7) == 0);
        end
        idle(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
